// File: rtl/mysys_key_pio.sv
// rtl/mysys_key_pio.sv - Avalon-MM input PIO with synchroniser, per-bit debounce, edge capture and irq

module mysys_key_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // A zero debounce setting still needs a legal one-bit counter that simply stays idle.
    localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (DEBOUNCE_CYCLES > 0) ? CW'(DEBOUNCE_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] cap_clr;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign cap_clr      = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^writedata;

    // Debounce: a synced bit must disagree with the accepted value for DEBOUNCE_CYCLES
    // consecutive cycles; any agreeing cycle restarts the count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (DEBOUNCE_CYCLES == 0) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Edge detection on the accepted value; a new edge outranks a same-cycle clear.
    always_comb begin
        case (EDGE_TYPE)
            0:       edge_set = stable_d & ~stable_q;
            1:       edge_set = ~stable_d & stable_q;
            default: edge_set = stable_d ^ stable_q;
        endcase
        cap_d  = (cap_q & ~cap_clr) | edge_set;
        mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
    end

    // State registers: synchroniser chain, debounce state, mask and sticky captures.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            mask_q   <= '0;
            cap_q    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= in_port;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            mask_q   <= mask_d;
            cap_q    <= cap_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Zero-latency register read, not gated by chipselect.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = stable_q;
            2'd2:    readdata[WIDTH-1:0] = mask_q;
            2'd3:    readdata[WIDTH-1:0] = cap_q;
            default: readdata = '0;
        endcase
    end

    assign irq = |(cap_q & mask_q);

endmodule
